packet_pb_server: RTL and testbench
===================================

Name: packet_pb_server

Overview:
- Serving end of the packet-playback handshake: owns the shared playback RAM's per-TG packet queues.
- Drives the per-TG ready vector that the round-robin playback arbiter consumes.
- On receiving a one-hot select grant, reads the granted TG's oldest packet out of RAM and streams it word by word to that TG.
- Also gives the packet loader a credit/address interface for filling the queues.

Parameters:
- N, 4, number of traffic generators (power of two, ≥2).
- DEPTH, 8, packets per TG region (power of two).
- PKT_WORDS, 4, words per packet (power of two, ≥2).
- W, 32, data word width.
- Derived: TW = log2(N); PW = log2(DEPTH); WW = log2(PKT_WORDS); AW = TW+PW+WW.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ready  out  N  TG i has ≥1 packet queued and server idle
- select  in  N  one-hot grant from arbiter; all-zero means no grant
- load_valid  in  1  loader commits one fully written packet for load_tg
- load_tg  in  TW  binary TG index of the commit
- load_ready  out  1  queue of load_tg not full (combinational on load_tg)
- load_addr  out  AW  word-0 RAM address the loader must write next for load_tg
- mem_re  out  1  RAM read enable
- mem_addr  out  AW  RAM read address
- mem_rdata  in  W  RAM read data, valid exactly 1 cycle after mem_re
- out_valid  out  1  out_data valid this cycle
- out_data  out  W  packet word
- out_dest  out  N  one-hot destination TG of out_data
- out_last  out  1  final word of packet
- err  out  1  sticky protocol-error flag

Behaviour:
- RAM layout: address = {tg, slot, word}; tg in MSBs, word in LSBs.
- Per-TG state:
  - count[i], PW+1 bits, range 0..DEPTH.
  - rd_ptr[i], wr_ptr[i], PW bits each; wrap modulo DEPTH naturally.
- load_ready = (count[load_tg] != DEPTH).
- load_addr = {load_tg, wr_ptr[load_tg], WW'b0}.
- Load accepted when load_valid && load_ready: wr_ptr[load_tg]++ and count[load_tg]++.
- load_valid while full: ignored, err set.
- FSM IDLE / READ. ready[i] = (state==IDLE) && (count[i]!=0), combinational. ready is all-zero in READ.
- IDLE:
  - If select is one-hot and ready[sel] is set: latch cur_tg = index(sel), word = 0, go to READ. No mem_re issued this cycle.
  - If select is non-zero and either not one-hot or granting a TG with ready low: ignore the grant, set err, stay in IDLE.
- READ, each cycle:
  - mem_re = 1, mem_addr = {cur_tg, rd_ptr[cur_tg], word}, word++.
  - On the cycle word == PKT_WORDS-1: rd_ptr[cur_tg]++, count[cur_tg]--, return to IDLE.
- Any non-zero select while in READ: ignored, err set.
- Output pipeline: registered, 1-cycle delay after mem_re.
  - out_valid = mem_re delayed by one cycle.
  - out_data = mem_rdata, combinational pass-through during the out_valid cycle.
  - out_dest = onehot(cur_tg) delayed; out_last = (word==PKT_WORDS-1) delayed.
  - No backpressure: the TG must accept every word.
- Latency:
  - Grant in cycle t → first mem_re at t+1 → first out_valid at t+2.
  - Last out_valid (out_last) at t+PKT_WORDS+1.
  - ready re-evaluated in IDLE at t+PKT_WORDS+1.
  - Back-to-back packets: one idle gap cycle on mem_re, none on the output beyond that.
- Simultaneous load and consume on the same TG in the same cycle: count unchanged, both pointers advance.
  - A load into a full queue during that TG's final READ cycle is still refused; load_ready uses the pre-update count.
- Load into a TG's empty queue: ready[i] asserts the cycle after the commit (registered count).
- Reset values:
  - state=IDLE; all count/rd_ptr/wr_ptr = 0.
  - ready=0, mem_re=0, out_valid=0, out_last=0, out_dest=0, out_data don't-care, err=0.
- Reset mid-packet: aborts immediately; no further out_valid; the partial packet is dropped, and its queue entry is discarded along with all queue state.

Test Plan:
- Load 1 packet for TG2 (load_addr must read 0x40); grant select=4'b0100 at t → mem_addr 0x40..0x43 at t+1..t+4; out_valid t+2..t+5, out_dest=4'b0100, out_last only at t+5; ready[2]=0 afterwards, count[2]=0.
- Load 8 packets into TG0 → load_ready=0 on 9th attempt; that load_valid sets err and count stays 8. Next load_addr values progress 0x00,0x04,...,0x1C; wrap back to 0x00 after drain and reload.
- Grant TG1 while TG3 also loaded → ready=4'b0000 during READ. A forced select=4'b1000 mid-READ sets err and produces no extra reads.
- TG1 holds 1 packet; load commit to TG1 on the same cycle as its last READ word → count[1] remains 1, ready[1]=1 on return to IDLE.
- select=4'b0110 in IDLE → no mem_re, err=1, state stays IDLE.
- Assert reset during the 3rd READ cycle → next cycle mem_re=0, out_valid=0 after one cycle, all counts 0, ready=0.

Source files
------------

// File: rtl/packet_pb_server_if.sv
// Playback server bundle: arbiter grant/ready, loader credit/address, RAM read port, TG output stream.
// Pure wiring with no latency; the only flow control is the loader's load_ready credit.
// master = arbiter/loader/RAM/TG side, slave = the server itself.
interface packet_pb_server_if #(
    parameter int N         = 4,
    parameter int DEPTH     = 8,
    parameter int PKT_WORDS = 4,
    parameter int W         = 32
);
    localparam int TW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = $clog2(PKT_WORDS);
    localparam int AW = TW + PW + WW;

    logic [N-1:0]  ready;
    logic [N-1:0]  select;
    logic          load_valid;
    logic [TW-1:0] load_tg;
    logic          load_ready;
    logic [AW-1:0] load_addr;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_rdata;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [N-1:0]  out_dest;
    logic          out_last;
    logic          err;

    modport master (
        output select, load_valid, load_tg, mem_rdata,
        input  ready, load_ready, load_addr, mem_re, mem_addr,
        input  out_valid, out_data, out_dest, out_last, err
    );

    modport slave (
        input  select, load_valid, load_tg, mem_rdata,
        output ready, load_ready, load_addr, mem_re, mem_addr,
        output out_valid, out_data, out_dest, out_last, err
    );
endinterface

// File: rtl/packet_pb_server.sv
// Owns the per-TG packet queues in playback RAM and streams a granted TG's oldest packet word by word.
// Grant at t: RAM reads t+1..t+PKT_WORDS, output words t+2..t+PKT_WORDS+1.
// No output backpressure; the loader is throttled by load_ready, and bad grants/loads raise sticky err.
module packet_pb_server #(
    parameter int N         = 4,
    parameter int DEPTH     = 8,
    parameter int PKT_WORDS = 4,
    parameter int W         = 32
) (
    input  logic               clock,
    input  logic               reset,
    packet_pb_server_if.slave  bus
);
    localparam int TW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = $clog2(PKT_WORDS);

    typedef enum logic {IDLE, READ} state_t;

    state_t        state_q, state_d;
    logic [PW:0]   count  [N];
    logic [PW-1:0] rd_ptr [N];
    logic [PW-1:0] wr_ptr [N];
    logic [TW-1:0] cur_tg;
    logic [TW-1:0] sel_idx;
    logic [WW-1:0] word;
    logic [N-1:0]  ready_vec;
    logic [N-1:0]  cur_onehot;
    logic          sel_onehot;
    logic          grant;
    logic          sel_err;
    logic          last_rd;
    logic          load_acc;
    logic          load_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant        = 1'b0;
        last_rd      = 1'b0;
        ready_vec    = '0;
        sel_idx      = '0;
        cur_onehot   = '0;
        bus.mem_re   = 1'b0;
        bus.mem_addr = {cur_tg, rd_ptr[cur_tg], word};

        for (int i = 0; i < N; i++) begin
            if (bus.select[i]) begin
                sel_idx = i[TW-1:0];
            end
        end
        cur_onehot[cur_tg] = 1'b1;
        sel_onehot = (bus.select != '0) && ((bus.select & (bus.select - 1'b1)) == '0);

        case (state_q)
            IDLE: begin
                for (int i = 0; i < N; i++) begin
                    ready_vec[i] = (count[i] != '0);
                end
                if (sel_onehot && ready_vec[sel_idx]) begin
                    grant   = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                bus.mem_re = 1'b1;
                if (word == WW'(PKT_WORDS - 1)) begin
                    last_rd = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Any grant that does not start a read (malformed, not ready, or while busy) is an error.
        sel_err        = (bus.select != '0) && !grant;
        bus.load_ready = (count[bus.load_tg] != (PW+1)'(DEPTH));
        bus.load_addr  = {bus.load_tg, wr_ptr[bus.load_tg], {WW{1'b0}}};
        load_acc       = bus.load_valid && bus.load_ready;
        load_err       = bus.load_valid && !bus.load_ready;
    end

    assign bus.ready    = ready_vec;
    assign bus.out_data = bus.mem_rdata[W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_tg        <= '0;
            word          <= '0;
            bus.err       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_dest  <= '0;
            for (int i = 0; i < N; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else begin
            bus.err       <= bus.err | sel_err | load_err;
            bus.out_valid <= bus.mem_re;
            bus.out_last  <= last_rd;
            bus.out_dest  <= bus.mem_re ? cur_onehot : '0;

            if (grant) begin
                cur_tg <= sel_idx;
                word   <= '0;
            end else if (state_q == READ) begin
                word <= word + 1'b1;
            end

            // A same-cycle load and final read on one TG moves both pointers and leaves count alone.
            for (int i = 0; i < N; i++) begin
                if (load_acc && (bus.load_tg == i[TW-1:0])) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (last_rd && (cur_tg == i[TW-1:0])) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                case ({load_acc && (bus.load_tg == i[TW-1:0]), last_rd && (cur_tg == i[TW-1:0])})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end
endmodule

// File: tb/tb_packet_pb_server.sv
// Bench for packet_pb_server: directed scenarios plus a random run against a queue-level model.
module tb_packet_pb_server;
    localparam int N = 4, DEPTH = 8, PKT_WORDS = 4, W = 32;
    localparam int TW = 2, AW = 7;
    localparam int REGION = DEPTH * PKT_WORDS;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    packet_pb_server_if #(.N(N), .DEPTH(DEPTH), .PKT_WORDS(PKT_WORDS), .W(W)) bus ();

    packet_pb_server #(.N(N), .DEPTH(DEPTH), .PKT_WORDS(PKT_WORDS), .W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [W-1:0] ram [2**AW];
    always @(posedge clock) if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];

    int checks = 0;
    int fails  = 0;

    // Model: queue occupancy and slot indices per TG, plus "which packet word is in flight".
    int cnt [N], rd [N], wr [N];
    bit busy, merr, pv, pl;
    int cur, widx, pa, pt;
    bit d_rst, d_grant, d_lacc, d_err;
    int d_idx, d_ltg;

    logic [N-1:0]  e_ready, e_dest;
    logic [AW-1:0] e_la, e_ma;
    logic [W-1:0]  e_od;
    bit            e_lr, e_re, e_ov, e_ol, e_err;

    task automatic drive(input bit rst, input logic [N-1:0] sel, input bit lv, input int ltg);
        @(negedge clock);
        reset          = rst;
        bus.select     = sel;
        bus.load_valid = lv;
        bus.load_tg    = ltg[TW-1:0];
        #1;
        for (int i = 0; i < N; i++) e_ready[i] = !busy && cnt[i] != 0;
        e_lr   = cnt[ltg] != DEPTH;
        e_la   = AW'(ltg * REGION + wr[ltg] * PKT_WORDS);
        e_re   = busy;
        e_ma   = AW'(cur * REGION + rd[cur] * PKT_WORDS + widx);
        e_ov   = pv;
        e_od   = ram[pa];
        e_dest = pv ? N'(1 << pt) : '0;
        e_ol   = pv && pl;
        e_err  = merr;
        d_idx  = 0;
        for (int i = 0; i < N; i++) if (sel[i]) d_idx = i;
        d_grant = !busy && $countones(sel) == 1 && cnt[d_idx] != 0;
        d_lacc  = lv && cnt[ltg] != DEPTH;
        d_err   = (sel != '0 && !d_grant) || (lv && !d_lacc);
        d_rst   = rst;
        d_ltg   = ltg;
    endtask

    task automatic tick();
        @(posedge clock);
        if (d_rst) begin
            for (int i = 0; i < N; i++) begin cnt[i] = 0; rd[i] = 0; wr[i] = 0; end
            busy = 0; merr = 0; pv = 0; pl = 0; cur = 0; widx = 0; pa = 0; pt = 0;
        end else begin
            pv = busy; pa = int'(e_ma); pt = cur; pl = busy && widx == PKT_WORDS - 1;
            if (d_err) merr = 1;
            if (busy) begin
                if (widx == PKT_WORDS - 1) begin
                    busy = 0; rd[cur] = (rd[cur] + 1) % DEPTH; cnt[cur]--;
                end else widx++;
            end
            if (d_lacc) begin wr[d_ltg] = (wr[d_ltg] + 1) % DEPTH; cnt[d_ltg]++; end
            if (d_grant) begin busy = 1; cur = d_idx; widx = 0; end
        end
    endtask

    task automatic step(input logic [N-1:0] sel, input bit lv, input int ltg);
        drive(0, sel, lv, ltg);
        tick();
    endtask

    task automatic do_reset();
        drive(1, '0, 0, 0); tick();
        drive(1, '0, 0, 0); tick();
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, '0, 0, 0);
        checks++;
        if (bus.ready !== 4'b0000 || bus.mem_re !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.out_last !== 1'b0 || bus.out_dest !== 4'b0000 || bus.err !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: ready=%b mem_re=%b ov=%b ol=%b dest=%b err=%b, all required 0",
                     bus.ready, bus.mem_re, bus.out_valid, bus.out_last, bus.out_dest, bus.err);
        end
        tick();
    endtask

    task automatic test_single_packet();
        do_reset();
        drive(0, '0, 1, 2);
        checks++;
        if (bus.load_addr !== 7'h40 || bus.load_ready !== 1'b1) begin
            fails++; $display("FAIL single_load: addr=%h rdy=%b, required 40 1", bus.load_addr, bus.load_ready);
        end
        tick();
        drive(0, '0, 0, 0);
        checks++;
        if (bus.ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b required 0100", bus.ready); end
        tick();
        drive(0, 4'b0100, 0, 0);
        checks++;
        if (bus.mem_re !== 1'b0) begin fails++; $display("FAIL single_grant_re: got %b required 0", bus.mem_re); end
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(0, '0, 0, 0);
            checks++;
            if (bus.mem_re !== (k <= 4) || (k <= 4 && bus.mem_addr !== 7'(8'h40 + k - 1))) begin
                fails++; $display("FAIL single_read t+%0d: re=%b addr=%h", k, bus.mem_re, bus.mem_addr);
            end
            checks++;
            if (bus.out_valid !== (k >= 2) || bus.out_dest !== ((k >= 2) ? 4'b0100 : 4'b0000) ||
                bus.out_last !== (k == 5) || (k >= 2 && bus.out_data !== ram[8'h40 + k - 2])) begin
                fails++; $display("FAIL single_out t+%0d: ov=%b dest=%b last=%b data=%h", k,
                                  bus.out_valid, bus.out_dest, bus.out_last, bus.out_data);
            end
            checks++;
            if (bus.ready !== 4'b0000) begin fails++; $display("FAIL single_ready_after t+%0d: got %b required 0000", k, bus.ready); end
            tick();
        end
    endtask

    task automatic test_fill_and_wrap();
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            drive(0, '0, 1, 0);
            checks++;
            if (bus.load_addr !== 7'(k * 4) || bus.load_ready !== 1'b1) begin
                fails++; $display("FAIL fill_addr %0d: addr=%h rdy=%b required %h 1", k, bus.load_addr, bus.load_ready, k * 4);
            end
            tick();
        end
        drive(0, '0, 1, 0);
        checks++;
        if (bus.load_ready !== 1'b0) begin fails++; $display("FAIL fill_full: load_ready=%b required 0", bus.load_ready); end
        tick();
        for (int p = 0; p < DEPTH; p++) begin
            drive(0, 4'b0001, 0, 0);
            checks++;
            if (bus.err !== 1'b1 || bus.mem_re !== 1'b0 || bus.out_valid !== (p > 0) || bus.out_last !== (p > 0)) begin
                fails++; $display("FAIL drain_grant %0d: err=%b re=%b ov=%b ol=%b", p, bus.err, bus.mem_re, bus.out_valid, bus.out_last);
            end
            checks++;
            if (p == 0 && bus.load_ready !== 1'b0) begin fails++; $display("FAIL fill_count_held: load_ready=%b required 0", bus.load_ready); end
            tick();
            for (int w = 0; w < PKT_WORDS; w++) begin
                drive(0, '0, 0, 0);
                checks++;
                if (bus.mem_re !== 1'b1 || bus.mem_addr !== 7'(p * 4 + w)) begin
                    fails++; $display("FAIL drain_addr %0d.%0d: re=%b addr=%h required %h", p, w, bus.mem_re, bus.mem_addr, p * 4 + w);
                end
                tick();
            end
        end
        drive(0, '0, 1, 0);
        checks++;
        if (bus.load_addr !== 7'h00 || bus.load_ready !== 1'b1 || bus.ready !== 4'b0000) begin
            fails++; $display("FAIL wrap_reload: addr=%h rdy=%b ready=%b required 00 1 0000", bus.load_addr, bus.load_ready, bus.ready);
        end
        tick();
    endtask

    task automatic test_busy_select();
        do_reset();
        step('0, 1, 1);
        step('0, 1, 3);
        step(4'b0010, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            drive(0, (k == 2) ? 4'b1000 : 4'b0000, 0, 0);
            checks++;
            if (bus.ready !== 4'b0000 || bus.mem_re !== 1'b1 || bus.mem_addr !== 7'(8'h20 + k - 1)) begin
                fails++; $display("FAIL busy_read %0d: ready=%b re=%b addr=%h", k, bus.ready, bus.mem_re, bus.mem_addr);
            end
            tick();
        end
        drive(0, '0, 0, 0);
        checks++;
        if (bus.mem_re !== 1'b0 || bus.err !== 1'b1 || bus.ready !== 4'b1000) begin
            fails++; $display("FAIL busy_after: re=%b err=%b ready=%b required 0 1 1000", bus.mem_re, bus.err, bus.ready);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        step('0, 1, 1);
        step('0, 0, 0);
        step(4'b0010, 0, 0);
        for (int w = 0; w < PKT_WORDS - 1; w++) step('0, 0, 0);
        drive(0, '0, 1, 1);
        checks++;
        if (bus.mem_addr !== 7'h23 || bus.load_ready !== 1'b1 || bus.load_addr !== 7'h24) begin
            fails++; $display("FAIL simul_last: addr=%h rdy=%b laddr=%h required 23 1 24", bus.mem_addr, bus.load_ready, bus.load_addr);
        end
        tick();
        drive(0, 4'b0010, 0, 0);
        checks++;
        if (bus.ready !== 4'b0010 || bus.err !== 1'b0) begin
            fails++; $display("FAIL simul_ready: ready=%b err=%b required 0010 0", bus.ready, bus.err);
        end
        tick();
        drive(0, '0, 0, 0);
        checks++;
        if (bus.mem_addr !== 7'h24) begin fails++; $display("FAIL simul_slot: addr=%h required 24", bus.mem_addr); end
        tick();
    endtask

    task automatic test_bad_select();
        do_reset();
        step('0, 1, 1);
        step('0, 1, 2);
        drive(0, 4'b0110, 0, 0);
        checks++;
        if (bus.mem_re !== 1'b0) begin fails++; $display("FAIL bad_sel_re: got %b required 0", bus.mem_re); end
        tick();
        drive(0, '0, 0, 0);
        checks++;
        if (bus.mem_re !== 1'b0 || bus.err !== 1'b1 || bus.ready !== 4'b0110) begin
            fails++; $display("FAIL bad_sel_after: re=%b err=%b ready=%b required 0 1 0110", bus.mem_re, bus.err, bus.ready);
        end
        tick();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        step('0, 1, 2);
        step(4'b0100, 0, 0);
        step('0, 0, 0);
        step('0, 0, 0);
        drive(1, '0, 0, 0);
        tick();
        drive(0, '0, 0, 0);
        checks++;
        if (bus.mem_re !== 1'b0 || bus.out_valid !== 1'b0 || bus.ready !== 4'b0000 ||
            bus.err !== 1'b0 || bus.load_addr !== 7'h00) begin
            fails++; $display("FAIL reset_mid: re=%b ov=%b ready=%b err=%b laddr=%h", bus.mem_re, bus.out_valid, bus.ready, bus.err, bus.load_addr);
        end
        tick();
        drive(0, '0, 0, 2);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.load_addr !== 7'h40) begin
            fails++; $display("FAIL reset_mid_after: ov=%b laddr=%h required 0 40", bus.out_valid, bus.load_addr);
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] sel;
        int r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 9);
            if (r < 4) sel = N'(1 << $urandom_range(0, N - 1));
            else if (r == 4) sel = N'($urandom_range(0, 15));
            else sel = '0;
            drive(0, sel, $urandom_range(0, 2) == 0, $urandom_range(0, N - 1));
            checks++;
            if (bus.ready !== e_ready || bus.load_ready !== e_lr || bus.load_addr !== e_la) begin
                fails++; $display("FAIL rand_ctl c%0d: ready=%b/%b lrdy=%b/%b laddr=%h/%h (got/required)", c,
                                  bus.ready, e_ready, bus.load_ready, e_lr, bus.load_addr, e_la);
            end
            checks++;
            if (bus.mem_re !== e_re || (e_re && bus.mem_addr !== e_ma)) begin
                fails++; $display("FAIL rand_mem c%0d: re=%b/%b addr=%h/%h (got/required)", c, bus.mem_re, e_re, bus.mem_addr, e_ma);
            end
            checks++;
            if (bus.out_valid !== e_ov || bus.out_dest !== e_dest || bus.out_last !== e_ol ||
                (e_ov && bus.out_data !== e_od)) begin
                fails++; $display("FAIL rand_out c%0d: ov=%b/%b dest=%b/%b last=%b/%b data=%h/%h (got/required)", c,
                                  bus.out_valid, e_ov, bus.out_dest, e_dest, bus.out_last, e_ol, bus.out_data, e_od);
            end
            checks++;
            if (bus.err !== e_err) begin fails++; $display("FAIL rand_err c%0d: got %b required %b", c, bus.err, e_err); end
            tick();
        end
    endtask

    initial begin
        bus.select     = '0;
        bus.load_valid = 1'b0;
        bus.load_tg    = '0;
        for (int a = 0; a < 2**AW; a++) ram[a] = $urandom;
        test_reset();
        test_single_packet();
        test_fill_and_wrap();
        test_busy_select();
        test_simultaneous();
        test_bad_select();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
